// File: rtl/vga_buffer_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_buffer_ctrl
//
// Sequences the IMG_W x IMG_H x PIX_W frame buffer RAM that sits between the
// masking accelerator and the VGA output stage.
//
// Write side: after a start pulse, accepts exactly one frame of raster-order
// pixels over a valid/ready handshake. Each accepted pixel becomes one RAM
// write on the following cycle (wr_en / pixel_row / pixel_col / pixel_result).
// frame_done is raised together with the write of the final pixel.
//
// Read side: runs continuously, independent of the capture FSM. The 640x480
// scan position is halved to give 2x pixel doubling onto the buffer. The RAM
// address is registered, the RAM answers one cycle later, and the returned
// pixel is gated by a two-cycle-delayed video_on. Total latency from
// vga_x/vga_y to vga_rgb is two cycles.
//
// Ports
//   clk, rst          system clock; synchronous active-high reset
//   start             one-cycle pulse, arms capture of one frame (IDLE only)
//   in_valid/in_ready input pixel handshake; in_pixel is the pixel data
//   pixel_result      RAM write data
//   pixel_row/col     RAM write address
//   wr_en             RAM write enable
//   busy              capture in progress (WRITE or DONE)
//   frame_done        one-cycle pulse with the final pixel's write
//   vga_x/vga_y       VGA scan position; video_on is the active-video flag
//   row_read/col_read RAM read address
//   pixel_out         RAM read data (one-cycle synchronous read)
//   vga_rgb           pixel to the DAC, zero when blanked
// -----------------------------------------------------------------------------
module vga_buffer_ctrl #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int PIX_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  // capture control
  input  logic             start,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             in_ready,
  // RAM write port
  output logic [PIX_W-1:0] pixel_result,
  output logic [7:0]       pixel_row,
  output logic [8:0]       pixel_col,
  output logic             wr_en,
  // status
  output logic             busy,
  output logic             frame_done,
  // VGA scan side
  input  logic [9:0]       vga_x,
  input  logic [9:0]       vga_y,
  input  logic             video_on,
  // RAM read port
  output logic [7:0]       row_read,
  output logic [8:0]       col_read,
  input  logic [PIX_W-1:0] pixel_out,
  output logic [PIX_W-1:0] vga_rgb
);

  localparam logic [7:0] ROW_LAST = 8'(IMG_H - 1);
  localparam logic [8:0] COL_LAST = 9'(IMG_W - 1);
  localparam logic [9:0] SCAN_W   = 10'(2 * IMG_W);
  localparam logic [9:0] SCAN_H   = 10'(2 * IMG_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [7:0] wr_row;
  logic [8:0] wr_col;
  logic       xfer;
  logic       last_pix;

  // A pixel moves only when both sides agree in the same cycle.
  assign xfer     = in_valid && in_ready;
  assign last_pix = (wr_row == ROW_LAST) && (wr_col == COL_LAST);

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours, exactly like hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next is given a default before the case so that no path leaves
  // it unassigned; otherwise synthesis would infer a latch to hold it.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)             state_next = WRITE;
      WRITE:   if (xfer && last_pix)  state_next = DONE;
      DONE:                           state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // in_ready and busy are flops loaded from the next state, so in_ready rises
  // together with entry to WRITE and falls right after the last transfer,
  // leaving no window for an extra pixel to slip in.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      in_ready <= (state_next == WRITE);
      busy     <= (state_next != IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Raster write counters: column first, row advances on column wrap.
  // Both are cleared when a new frame is armed; a start seen outside IDLE has
  // no effect on them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_row <= '0;
      wr_col <= '0;
    end else if ((state == IDLE) && start) begin
      wr_row <= '0;
      wr_col <= '0;
    end else if (xfer) begin
      if (wr_col == COL_LAST) begin
        wr_col <= '0;
        wr_row <= (wr_row == ROW_LAST) ? '0 : wr_row + 8'd1;
      end else begin
        wr_col <= wr_col + 9'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RAM write port: one write per accepted pixel, one cycle after acceptance,
  // addressed with the counter values at the moment of the transfer.
  // Data and address hold their last value between writes; only wr_en
  // qualifies them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en        <= 1'b0;
      frame_done   <= 1'b0;
      pixel_result <= '0;
      pixel_row    <= '0;
      pixel_col    <= '0;
    end else begin
      wr_en      <= xfer;
      frame_done <= xfer && last_pix;
      if (xfer) begin
        pixel_result <= in_pixel;
        pixel_row    <= wr_row;
        pixel_col    <= wr_col;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic in_view;
  logic video_on_d1;
  logic video_on_d2;

  // Outside the visible 640x480 window (or while blanked) the address parks
  // at 0 rather than wrapping onto real buffer content.
  assign in_view = video_on && (vga_x < SCAN_W) && (vga_y < SCAN_H);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_read    <= '0;
      col_read    <= '0;
      video_on_d1 <= 1'b0;
      video_on_d2 <= 1'b0;
    end else begin
      // Dropping bit 0 of each coordinate doubles every buffer pixel in both
      // directions.
      row_read    <= in_view ? vga_y[8:1] : 8'd0;
      col_read    <= in_view ? vga_x[9:1] : 9'd0;
      video_on_d1 <= video_on;
      video_on_d2 <= video_on_d1;
    end
  end

  // The RAM output is already registered, so gating it here keeps the
  // two-cycle latency the timing generator's sync delay is built around.
  assign vga_rgb = video_on_d2 ? pixel_out : '0;

endmodule

// File: tb/tb_vga_buffer_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_vga_buffer_ctrl
//
// Self-checking bench for vga_buffer_ctrl. A reference model runs alongside
// the DUT: the write side is described as "frame phase + accepted pixel
// index", with addresses derived as index / IMG_W and index % IMG_W; the read
// side keeps the last two scan samples and derives addresses by halving the
// coordinates. A small behavioural RAM answers read addresses one cycle later
// with a fixed content function.
// -----------------------------------------------------------------------------
module tb_vga_buffer_ctrl;

  localparam int IMG_W     = 320;
  localparam int IMG_H     = 240;
  localparam int PIX_W     = 12;
  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int FRAME_BUDGET = 90000;

  logic             clk;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic [PIX_W-1:0] in_pixel;
  logic             in_ready;
  logic [PIX_W-1:0] pixel_result;
  logic [7:0]       pixel_row;
  logic [8:0]       pixel_col;
  logic             wr_en;
  logic             busy;
  logic             frame_done;
  logic [9:0]       vga_x;
  logic [9:0]       vga_y;
  logic             video_on;
  logic [7:0]       row_read;
  logic [8:0]       col_read;
  logic [PIX_W-1:0] pixel_out;
  logic [PIX_W-1:0] vga_rgb;

  vga_buffer_ctrl #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .PIX_W(PIX_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_pixel     (in_pixel),
    .in_ready     (in_ready),
    .pixel_result (pixel_result),
    .pixel_row    (pixel_row),
    .pixel_col    (pixel_col),
    .wr_en        (wr_en),
    .busy         (busy),
    .frame_done   (frame_done),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .video_on     (video_on),
    .row_read     (row_read),
    .col_read     (col_read),
    .pixel_out    (pixel_out),
    .vga_rgb      (vga_rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_tests  = 0;
  int n_failed = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural frame-buffer RAM (read port only). (0,0) holds zero and
  // (2,1) holds 0xABC; everything else is a scrambled function of position.
  // ---------------------------------------------------------------------------
  function automatic logic [PIX_W-1:0] mem_val(input int r, input int c);
    if (r == 2 && c == 1) return 12'hABC;
    return PIX_W'((r * IMG_W + c) * 7);
  endfunction

  initial pixel_out = '0;
  always @(posedge clk) pixel_out = mem_val(int'(row_read), int'(col_read));

  // ---------------------------------------------------------------------------
  // Reference model + per-cycle comparison
  // ---------------------------------------------------------------------------
  int  m_phase  = 0;   // 0 idle, 1 capturing, 2 frame just finished
  int  m_idx    = 0;   // pixels accepted in the current frame
  int  m_frames = 0;
  bit  e_ready = 0, e_busy = 0, e_wr = 0, e_done = 0, after_rst = 0;
  int  e_row = 0, e_col = 0;
  logic [PIX_W-1:0] e_data = '0;

  bit  a1_vo = 0, a2_vo = 0;
  int  a1_row = 0, a1_col = 0, a2_row = 0, a2_col = 0;

  int  wr_count = 0, done_count = 0, last_row = 0, last_col = 0;
  logic [PIX_W-1:0] last_data = '0;

  always @(posedge clk) begin : model
    bit acc;
    bit vis;
    int sx, sy;
    acc = in_valid && e_ready;
    sx  = int'(vga_x);
    sy  = int'(vga_y);
    if (rst) begin
      m_phase   = 0;
      m_idx     = 0;
      e_ready   = 0;
      e_busy    = 0;
      e_wr      = 0;
      e_done    = 0;
      after_rst = 1;
      a1_vo = 0; a1_row = 0; a1_col = 0;
      a2_vo = 0; a2_row = 0; a2_col = 0;
    end else begin
      after_rst = 0;
      e_wr      = acc;
      e_done    = 0;
      if (acc) begin
        e_row  = m_idx / IMG_W;
        e_col  = m_idx % IMG_W;
        e_data = in_pixel;
        e_done = (m_idx == FRAME_PIX - 1);
      end
      case (m_phase)
        0: if (start) begin m_phase = 1; m_idx = 0; end
        1: if (acc) begin
             m_idx++;
             if (m_idx == FRAME_PIX) begin m_phase = 2; m_frames++; end
           end
        default: m_phase = 0;
      endcase
      e_ready = (m_phase == 1);
      e_busy  = (m_phase != 0);
      // read side: two-stage history of scan samples
      vis    = video_on && sx < 2 * IMG_W && sy < 2 * IMG_H;
      a2_vo  = a1_vo;  a2_row = a1_row;  a2_col = a1_col;
      a1_vo  = video_on;
      a1_row = vis ? sy / 2 : 0;
      a1_col = vis ? sx / 2 : 0;
    end

    #1;
    check("in_ready", in_ready, e_ready);
    check("busy", busy, e_busy);
    check("wr_en", wr_en, e_wr);
    check("frame_done", frame_done, e_done);
    if (e_wr) begin
      check("wr_row", pixel_row, e_row);
      check("wr_col", pixel_col, e_col);
      check("wr_data", pixel_result, e_data);
    end
    if (after_rst) begin
      check("rst_pixel_result", pixel_result, 0);
      check("rst_pixel_row", pixel_row, 0);
      check("rst_pixel_col", pixel_col, 0);
    end
    check("row_read", row_read, a1_row);
    check("col_read", col_read, a1_col);
    check("vga_rgb", vga_rgb, a2_vo ? mem_val(a2_row, a2_col) : '0);

    if (wr_en) begin
      wr_count++;
      last_row  = int'(pixel_row);
      last_col  = int'(pixel_col);
      last_data = pixel_result;
    end
    if (frame_done) done_count++;
  end

  // ---------------------------------------------------------------------------
  // Random scan stimulus, biased toward the visible-window edges
  // ---------------------------------------------------------------------------
  bit rd_directed = 0;

  always @(negedge clk) begin
    if (!rd_directed) begin
      if ($urandom_range(0, 3) == 0) vga_x = 10'(638 + $urandom_range(0, 3));
      else                           vga_x = 10'($urandom_range(0, 799));
      if ($urandom_range(0, 3) == 0) vga_y = 10'(478 + $urandom_range(0, 3));
      else                           vga_y = 10'($urandom_range(0, 524));
      video_on = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int done_before;
    bit dup_sent;
    bit finished;

    vga_x = '0; vga_y = '0; video_on = 1'b0;
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_pixel = 12'h5A5;

    // Reset held two cycles with start and in_valid asserted
    repeat (2) @(posedge clk);
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_vga_rgb", vga_rgb, 0);

    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_count = 0; done_count = 0;

    // Full frame: random backpressure for the first 2000 pixels, a stray
    // start at pixel 1000, then in_valid held high with in_pixel = index.
    dup_sent = 0;
    finished = 0;
    for (int cyc = 0; cyc < FRAME_BUDGET; cyc++) begin
      if (m_phase == 0 && m_frames == 1) begin finished = 1; break; end
      start = 1'b0;
      if (!dup_sent && m_idx == 1000) begin start = 1'b1; dup_sent = 1; end
      if (m_idx < 2000) begin
        in_valid = 1'($urandom_range(0, 1));
        in_pixel = PIX_W'($urandom);
      end else begin
        in_valid = 1'b1;
        in_pixel = PIX_W'(m_idx);
      end
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0;
    check("frame_finished", finished, 1);
    check("frame_wr_count", wr_count, FRAME_PIX);
    check("frame_done_count", done_count, 1);
    check("last_row", last_row, IMG_H - 1);
    check("last_col", last_col, IMG_W - 1);
    check("last_data", last_data, 12'hBFF);
    check("post_frame_in_ready", in_ready, 0);
    check("post_frame_busy", busy, 0);

    // Reset in the middle of a frame at pixel 5000
    done_before = done_count;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 6000 && m_idx < 5000; cyc++) begin
      in_pixel = PIX_W'(m_idx);
      @(negedge clk);
    end
    check("midrst_reached", m_idx, 5000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_count, done_before);

    // New start resumes at (0,0)
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_pixel = 12'h3C7;
    for (int cyc = 0; cyc < 10 && m_idx < 1; cyc++) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("restart_row", last_row, 0);
    check("restart_col", last_col, 0);
    check("restart_data", last_data, 12'h3C7);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && m_idx < 10; cyc++) begin
      in_pixel = PIX_W'(m_idx);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("restart_col_9", last_col, 9);
    check("restart_busy", busy, 1);

    // Directed read mapping
    rd_directed = 1;
    vga_x = 10'd3; vga_y = 10'd5; video_on = 1'b1;
    @(posedge clk); #2;
    check("map_row", row_read, 2);
    check("map_col", col_read, 1);
    @(negedge clk);
    vga_x = 10'd650; vga_y = 10'd5; video_on = 1'b1;
    @(posedge clk); #2;
    check("map_rgb_abc", vga_rgb, 12'hABC);
    check("offscreen_row", row_read, 0);
    check("offscreen_col", col_read, 0);
    @(negedge clk);
    vga_x = 10'd3; vga_y = 10'd5; video_on = 1'b0;
    @(posedge clk); #2;
    check("offscreen_rgb", vga_rgb, 0);
    check("blank_row", row_read, 0);
    check("blank_col", col_read, 0);
    @(negedge clk);
    vga_x = 10'd0; vga_y = 10'd0; video_on = 1'b0;
    @(posedge clk); #2;
    check("blank_rgb", vga_rgb, 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
